// File: rtl/uart_pkg.sv
// Shared UART definitions for the RX and TX sides.
// Contents:
//   DATA_BITS       - payload bits per frame
//   PACKET_SIZE     - bits on the line per frame (start + data + stop)
//   uart_rx_state_t - receiver FSM states
//   clks_per_baud() - system clocks per serial bit, truncated
package uart_pkg;

  localparam int DATA_BITS   = 8;
  localparam int PACKET_SIZE = 10;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } uart_rx_state_t;

  function automatic int clks_per_baud(input int clk_rate, input int baud_rate);
    return clk_rate / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Output side of the UART receiver: byte handshake plus error pulses.
// Signals:
//   data_read_ready  consumer -> receiver, consumer can accept data_out
//   data_read_valid  receiver -> consumer, data_out holds an unread byte
//   data_out         receiver -> consumer, received byte (LSB first on line)
//   frame_error      receiver -> consumer, one-cycle pulse, stop bit low
//   overrun          receiver -> consumer, one-cycle pulse, byte dropped
// Modports: master (receiver side), slave (consumer side).
interface uart_rx_if;
  import uart_pkg::*;

  logic                 data_read_ready;
  logic                 data_read_valid;
  logic [DATA_BITS-1:0] data_out;
  logic                 frame_error;
  logic                 overrun;

  modport master (
    input  data_read_ready,
    output data_read_valid,
    output data_out,
    output frame_error,
    output overrun
  );

  modport slave (
    output data_read_ready,
    input  data_read_valid,
    input  data_out,
    input  frame_error,
    input  overrun
  );

endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset, loads RESET_VAL into both flops
//   d      asynchronous input
//   q      synchronised output, lags d by two clocks
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_p0;
  logic sync_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_p0 <= RESET_VAL;
      sync_p1 <= RESET_VAL;
    end else begin
      meta_p0 <= d;
      sync_p1 <= meta_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and a one-entry output buffer.
// Ports:
//   clk       system clock, rising edge
//   areset_n  asynchronous active-low reset
//   rxd_in    asynchronous serial input, idles high
//   bus       uart_rx_if.master: valid/ready byte handshake, frame_error
//             and overrun one-cycle pulses
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_RATE  = 50000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic     clk,
  input  logic     areset_n,
  input  logic     rxd_in,
  uart_rx_if.master bus
);

  localparam int CPB   = clks_per_baud(CLK_RATE, BAUD_RATE);
  localparam int CNT_W = $clog2(CPB) + 1;
  // Half-bit load puts the start-bit sample at its centre; every later
  // sample then lands one full bit further on.
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CPB / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CPB - 1);

  if (CPB < 4) begin : g_cpb_check
    $error("uart_rx: CLKS_PER_BAUD must be at least 4");
  end

  logic                 rxd_s;
  uart_rx_state_t       state, state_nxt;
  logic [CNT_W-1:0]     clk_cnt, clk_cnt_nxt;
  logic [2:0]           bit_cnt, bit_cnt_nxt;
  logic [DATA_BITS-1:0] shift_reg, shift_nxt;
  logic                 commit;
  logic                 frame_err_nxt;

  logic                 valid_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 frame_error_q;
  logic                 overrun_q;
  logic                 transfer;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (areset_n),
    .d     (rxd_in),
    .q     (rxd_s)
  );

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clk_cnt <= clk_cnt_nxt;
      bit_cnt <= bit_cnt_nxt;
    end
  end

  // Payload shifter carries data only; its contents are meaningless until
  // eight samples of a frame have been taken.
  always_ff @(posedge clk) begin
    shift_reg <= shift_nxt;
  end

  always_comb begin
    state_nxt     = state;
    clk_cnt_nxt   = clk_cnt;
    bit_cnt_nxt   = bit_cnt;
    shift_nxt     = shift_reg;
    commit        = 1'b0;
    frame_err_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (!rxd_s) begin
          state_nxt   = START;
          clk_cnt_nxt = HALF_LOAD;
        end
      end
      START: begin
        if (clk_cnt == '0) begin
          if (!rxd_s) begin
            state_nxt   = DATA;
            clk_cnt_nxt = FULL_LOAD;
            bit_cnt_nxt = '0;
          end else begin
            // Line went back high before mid start bit: treat as a glitch.
            state_nxt = IDLE;
          end
        end else begin
          clk_cnt_nxt = clk_cnt - CNT_W'(1);
        end
      end
      DATA: begin
        if (clk_cnt == '0) begin
          shift_nxt   = {rxd_s, shift_reg[DATA_BITS-1:1]};
          clk_cnt_nxt = FULL_LOAD;
          if (bit_cnt == 3'd7) begin
            state_nxt = STOP;
          end else begin
            bit_cnt_nxt = bit_cnt + 3'd1;
          end
        end else begin
          clk_cnt_nxt = clk_cnt - CNT_W'(1);
        end
      end
      STOP: begin
        if (clk_cnt == '0) begin
          if (rxd_s) begin
            // Leave at mid stop bit so a back-to-back start edge is seen.
            commit    = 1'b1;
            state_nxt = IDLE;
          end else begin
            frame_err_nxt = 1'b1;
            state_nxt     = WAIT_HIGH;
          end
        end else begin
          clk_cnt_nxt = clk_cnt - CNT_W'(1);
        end
      end
      WAIT_HIGH: begin
        // A held-low (break) line must not look like endless start bits.
        if (rxd_s) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign transfer = valid_q && bus.data_read_ready;

  // Output buffer: one byte deep. A commit that coincides with a read
  // refills the buffer; a commit into a full, unread buffer is dropped.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      valid_q       <= 1'b0;
      data_q        <= '0;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      frame_error_q <= frame_err_nxt;
      overrun_q     <= 1'b0;
      if (commit) begin
        if (!valid_q || transfer) begin
          data_q  <= shift_reg;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (transfer) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.data_read_valid = valid_q;
  assign bus.data_out        = data_q;
  assign bus.frame_error     = frame_error_q;
  assign bus.overrun         = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit. The bench serialises
// 8N1 frames onto rxd_in (acting as the peer transmitter), pushes expected
// bytes into a scoreboard queue, logs every handshake transfer and counts
// error pulses in a negedge monitor, and compares inside each test task.
module tb_uart_rx;

  localparam int CLK_RATE  = 16;
  localparam int BAUD_RATE = 1;
  localparam int BIT_CLKS  = 16;

  logic clk = 1'b0;
  logic areset_n;
  logic rxd_in;

  uart_rx_if bus();

  uart_rx #(
    .CLK_RATE  (CLK_RATE),
    .BAUD_RATE (BAUD_RATE)
  ) dut (
    .clk      (clk),
    .areset_n (areset_n),
    .rxd_in   (rxd_in),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_log [0:1023];
  int rx_wr = 0;
  int rx_rd = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int vld_cycles = 0;

  // Monitor: values seen at negedge are the ones the next rising edge uses.
  always @(negedge clk) begin
    if (areset_n && bus.data_read_valid && bus.data_read_ready && rx_wr < 1024) begin
      rx_log[rx_wr] = bus.data_out;
      rx_wr = rx_wr + 1;
    end
    if (bus.frame_error) fe_cnt = fe_cnt + 1;
    if (bus.overrun) ov_cnt = ov_cnt + 1;
    if (bus.data_read_valid) vld_cycles = vld_cycles + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, finished=0 required=1");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd_in = f[i];
      tick(BIT_CLKS);
    end
  endtask

  task automatic wait_rx();
    for (int i = 0; i < 400; i++) begin
      if (rx_wr - rx_rd >= exp_q.size()) break;
      tick(1);
    end
  endtask

  task automatic test_reset();
    areset_n = 1'b0;
    rxd_in = 1'b1;
    bus.data_read_ready = 1'b1;
    tick(3);
    n_checks++;
    if (bus.data_read_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b want 0", bus.data_read_valid);
    end
    n_checks++;
    if (bus.data_out !== 8'h00) begin
      n_fail++; $display("FAIL reset_data: got %h want 00", bus.data_out);
    end
    n_checks++;
    if (bus.frame_error !== 1'b0) begin
      n_fail++; $display("FAIL reset_frame_error: got %b want 0", bus.frame_error);
    end
    n_checks++;
    if (bus.overrun !== 1'b0) begin
      n_fail++; $display("FAIL reset_overrun: got %b want 0", bus.overrun);
    end
    areset_n = 1'b1;
    tick(20);
  endtask

  task automatic test_basic();
    int fe0, ov0, v0;
    logic [7:0] got, exp;
    fe0 = fe_cnt; ov0 = ov_cnt; v0 = vld_cycles;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    tick(10);
    wait_rx();
    while (exp_q.size() > 0 && rx_rd < rx_wr) begin
      exp = exp_q.pop_front(); got = rx_log[rx_rd]; rx_rd++;
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL basic_data: got %h want %h", got, exp); end
    end
    n_checks++;
    if (exp_q.size() != 0 || rx_rd != rx_wr) begin
      n_fail++; $display("FAIL basic_count: pending %0d extra %0d want 0 0", exp_q.size(), rx_wr - rx_rd);
    end
    n_checks++;
    if (vld_cycles - v0 != 1) begin
      n_fail++; $display("FAIL basic_valid_cycles: got %0d want 1", vld_cycles - v0);
    end
    n_checks++;
    if (fe_cnt - fe0 != 0 || ov_cnt - ov0 != 0) begin
      n_fail++; $display("FAIL basic_flags: fe %0d ov %0d want 0 0", fe_cnt - fe0, ov_cnt - ov0);
    end
    exp_q.delete();
  endtask

  task automatic test_glitch();
    int fe0, v0;
    logic [7:0] got, exp;
    fe0 = fe_cnt; v0 = vld_cycles;
    rxd_in = 1'b0;
    tick(5);
    rxd_in = 1'b1;
    tick(40);
    n_checks++;
    if (vld_cycles - v0 != 0) begin
      n_fail++; $display("FAIL glitch_valid: got %0d cycles want 0", vld_cycles - v0);
    end
    n_checks++;
    if (fe_cnt - fe0 != 0) begin
      n_fail++; $display("FAIL glitch_frame_error: got %0d want 0", fe_cnt - fe0);
    end
    // Receiver must be back in idle and catch the next frame normally.
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    tick(10);
    wait_rx();
    while (exp_q.size() > 0 && rx_rd < rx_wr) begin
      exp = exp_q.pop_front(); got = rx_log[rx_rd]; rx_rd++;
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL glitch_next_data: got %h want %h", got, exp); end
    end
    n_checks++;
    if (exp_q.size() != 0 || rx_rd != rx_wr) begin
      n_fail++; $display("FAIL glitch_count: pending %0d extra %0d want 0 0", exp_q.size(), rx_wr - rx_rd);
    end
    exp_q.delete();
  endtask

  task automatic test_frame_error();
    int fe0, ov0;
    logic [7:0] got, exp;
    fe0 = fe_cnt; ov0 = ov_cnt;
    send_frame(8'h3C, 1'b0);
    rxd_in = 1'b0;
    tick(40);
    rxd_in = 1'b1;
    tick(BIT_CLKS);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    tick(10);
    wait_rx();
    while (exp_q.size() > 0 && rx_rd < rx_wr) begin
      exp = exp_q.pop_front(); got = rx_log[rx_rd]; rx_rd++;
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL ferr_data: got %h want %h", got, exp); end
    end
    n_checks++;
    if (exp_q.size() != 0 || rx_rd != rx_wr) begin
      n_fail++; $display("FAIL ferr_count: pending %0d extra %0d want 0 0", exp_q.size(), rx_wr - rx_rd);
    end
    n_checks++;
    if (fe_cnt - fe0 != 1) begin
      n_fail++; $display("FAIL ferr_pulses: got %0d want 1", fe_cnt - fe0);
    end
    n_checks++;
    if (ov_cnt - ov0 != 0) begin
      n_fail++; $display("FAIL ferr_overrun: got %0d want 0", ov_cnt - ov0);
    end
    exp_q.delete();
  endtask

  task automatic test_overrun();
    int ov0, fe0;
    logic [7:0] got, exp;
    ov0 = ov_cnt; fe0 = fe_cnt;
    bus.data_read_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    tick(10);
    n_checks++;
    if (ov_cnt - ov0 != 1) begin
      n_fail++; $display("FAIL overrun_pulses: got %0d want 1", ov_cnt - ov0);
    end
    n_checks++;
    if (bus.data_out !== 8'h11) begin
      n_fail++; $display("FAIL overrun_held_data: got %h want 11", bus.data_out);
    end
    n_checks++;
    if (bus.data_read_valid !== 1'b1) begin
      n_fail++; $display("FAIL overrun_held_valid: got %b want 1", bus.data_read_valid);
    end
    bus.data_read_ready = 1'b1;
    tick(3);
    wait_rx();
    while (exp_q.size() > 0 && rx_rd < rx_wr) begin
      exp = exp_q.pop_front(); got = rx_log[rx_rd]; rx_rd++;
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL overrun_read: got %h want %h", got, exp); end
    end
    n_checks++;
    if (exp_q.size() != 0 || rx_rd != rx_wr) begin
      n_fail++; $display("FAIL overrun_count: pending %0d extra %0d want 0 0", exp_q.size(), rx_wr - rx_rd);
    end
    n_checks++;
    if (bus.data_read_valid !== 1'b0 || fe_cnt - fe0 != 0) begin
      n_fail++; $display("FAIL overrun_after: valid %b fe %0d want 0 0", bus.data_read_valid, fe_cnt - fe0);
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int ov0;
    logic [7:0] got, exp, b2b_data;
    logic b2b_vld;
    ov0 = ov_cnt;
    bus.data_read_ready = 1'b0;
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hAA);
    send_frame(8'h55, 1'b1);
    // 0xAA starts right away; its stop-bit commit lands on the 155th edge.
    fork
      send_frame(8'hAA, 1'b1);
      begin
        tick(154);
        bus.data_read_ready = 1'b1;
        tick(1);
        bus.data_read_ready = 1'b0;
        b2b_data = bus.data_out;
        b2b_vld  = bus.data_read_valid;
      end
    join
    n_checks++;
    if (b2b_data !== 8'hAA) begin
      n_fail++; $display("FAIL b2b_replaced_data: got %h want aa", b2b_data);
    end
    n_checks++;
    if (b2b_vld !== 1'b1) begin
      n_fail++; $display("FAIL b2b_valid_kept: got %b want 1", b2b_vld);
    end
    bus.data_read_ready = 1'b1;
    tick(3);
    wait_rx();
    while (exp_q.size() > 0 && rx_rd < rx_wr) begin
      exp = exp_q.pop_front(); got = rx_log[rx_rd]; rx_rd++;
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL b2b_data: got %h want %h", got, exp); end
    end
    n_checks++;
    if (exp_q.size() != 0 || rx_rd != rx_wr) begin
      n_fail++; $display("FAIL b2b_count: pending %0d extra %0d want 0 0", exp_q.size(), rx_wr - rx_rd);
    end
    n_checks++;
    if (ov_cnt - ov0 != 0) begin
      n_fail++; $display("FAIL b2b_overrun: got %0d want 0", ov_cnt - ov0);
    end
    exp_q.delete();
  endtask

  task automatic test_mid_reset();
    int fe0, ov0, v0;
    logic [7:0] got, exp, rst_data;
    logic rst_vld;
    fe0 = fe_cnt; ov0 = ov_cnt;
    // 0xF0 ends in four 1 bits, so the line stays high after the abort.
    fork
      send_frame(8'hF0, 1'b1);
      begin
        tick(85);
        areset_n = 1'b0;
        tick(1);
        rst_data = bus.data_out;
        rst_vld  = bus.data_read_valid;
        tick(2);
        areset_n = 1'b1;
      end
    join
    v0 = vld_cycles;
    tick(20);
    n_checks++;
    if (rst_data !== 8'h00 || rst_vld !== 1'b0) begin
      n_fail++; $display("FAIL midrst_in_reset: data %h valid %b want 00 0", rst_data, rst_vld);
    end
    n_checks++;
    if (vld_cycles - v0 != 0 || bus.data_out !== 8'h00) begin
      n_fail++; $display("FAIL midrst_no_output: valid cycles %0d data %h want 0 00", vld_cycles - v0, bus.data_out);
    end
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1);
    tick(10);
    wait_rx();
    while (exp_q.size() > 0 && rx_rd < rx_wr) begin
      exp = exp_q.pop_front(); got = rx_log[rx_rd]; rx_rd++;
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL midrst_data: got %h want %h", got, exp); end
    end
    n_checks++;
    if (exp_q.size() != 0 || rx_rd != rx_wr) begin
      n_fail++; $display("FAIL midrst_count: pending %0d extra %0d want 0 0", exp_q.size(), rx_wr - rx_rd);
    end
    n_checks++;
    if (fe_cnt - fe0 != 0 || ov_cnt - ov0 != 0) begin
      n_fail++; $display("FAIL midrst_flags: fe %0d ov %0d want 0 0", fe_cnt - fe0, ov_cnt - ov0);
    end
    exp_q.delete();
  endtask

  task automatic test_loopback();
    int fe0, ov0;
    logic [7:0] b, got, exp;
    fe0 = fe_cnt; ov0 = ov_cnt;
    bus.data_read_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      send_frame(b, 1'b1);
    end
    tick(10);
    wait_rx();
    while (exp_q.size() > 0 && rx_rd < rx_wr) begin
      exp = exp_q.pop_front(); got = rx_log[rx_rd]; rx_rd++;
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL loop_data[%0d]: got %h want %h", rx_rd - 1, got, exp); end
    end
    n_checks++;
    if (exp_q.size() != 0 || rx_rd != rx_wr) begin
      n_fail++; $display("FAIL loop_count: pending %0d extra %0d want 0 0", exp_q.size(), rx_wr - rx_rd);
    end
    n_checks++;
    if (fe_cnt - fe0 != 0 || ov_cnt - ov0 != 0) begin
      n_fail++; $display("FAIL loop_flags: fe %0d ov %0d want 0 0", fe_cnt - fe0, ov_cnt - ov0);
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_back_to_back();
    test_mid_reset();
    test_loopback();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver; the downstream counterpart to the UART TX block, consuming a serial line such as the `txd_out` of a peer transmitter.
- Synchronises the asynchronous serial input and locates each start bit.
- Samples every bit at its mid-point and checks the stop bit.
- Delivers each byte through a one-entry output buffer with a valid/ready handshake, and flags framing and overrun errors.

Parameters:
- CLK_RATE, 50000000, system clock frequency in Hz.
- BAUD_RATE, 115200, serial bit rate in baud. CLKS_PER_BAUD = int'(CLK_RATE / BAUD_RATE). CLKS_PER_BAUD must be >= 4; a compile-time assertion checks this.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- areset_n  in  1  reset: one clock; reset is asynchronous and active-low.
- rxd_in  in  1  serial input, asynchronous to clk, idles high.
- data_read_ready  in  1  consumer can accept data_out this cycle.
- data_read_valid  out  1  data_out holds an unread byte.
- data_out  out  8  received byte, LSB is the first data bit on the line.
- frame_error  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: byte completed while the buffer was full and not being read.

Behaviour:
- Reset (areset_n low, asynchronous):
  - data_read_valid=0, data_out=0, frame_error=0, overrun=0.
  - Synchroniser flops = 1 (idle line).
  - State = IDLE; counters = 0.
  - Reset asserted mid-frame abandons the frame. No output pulses occur during or after reset.
- Synchroniser: 2 flops. rxd_s lags rxd_in by 2 cycles. All FSM decisions use rxd_s only.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: when rxd_s==0, go to START and load clk_cnt = CLKS_PER_BAUD/2 - 1.
  - START: decrement clk_cnt. At clk_cnt==0, sample rxd_s:
    - 0: go to DATA, with clk_cnt = CLKS_PER_BAUD - 1 and bit_cnt = 0.
    - 1: glitch; return to IDLE with no output.
  - DATA: decrement clk_cnt. At clk_cnt==0:
    - Shift rxd_s into shift_reg MSB, shifting right (LSB-first reception).
    - Reload clk_cnt = CLKS_PER_BAUD - 1.
    - After the 8th sample (bit_cnt==7), go to STOP; otherwise bit_cnt += 1.
  - STOP: decrement clk_cnt. At clk_cnt==0, sample rxd_s:
    - 1 (valid frame): commit shift_reg (see buffer rules) and go to IDLE. Mid-stop-bit exit allows a back-to-back start bit to be caught.
    - 0: pulse frame_error, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rxd_s==1, then go to IDLE. This stops a break condition from re-triggering continuously.
- Sampling: each sample is taken within ±1 cycle of the bit centre.
- Buffer and handshake:
  - data_read_valid is high while the buffer is full.
  - A transfer occurs on a cycle with data_read_valid && data_read_ready; data_read_valid drops the next cycle unless a commit happens in the same cycle.
  - Commit with buffer empty: data_out <= shift_reg, data_read_valid <= 1 on the next cycle.
  - Commit with buffer full and a transfer in the same cycle: the new byte replaces data_out, data_read_valid stays 1, and no overrun.
  - Commit with buffer full and no transfer: keep the old byte, drop the new byte, pulse overrun.
  - data_out is stable while data_read_valid=1 and no transfer has occurred.
- Latency: from the stop-bit centre sample to data_read_valid = 1 cycle.
- Counter widths: clk_cnt is $clog2(CLKS_PER_BAUD)+1 bits; bit_cnt is 3 bits. No wrap is possible because every reload happens at 0.

Decomposition:
- Shared package uart_pkg holds:
  - State enum uart_rx_state_t (IDLE, START, DATA, STOP, WAIT_HIGH).
  - DATA_BITS=8 and PACKET_SIZE=10.
  - Function clks_per_baud(clk_rate, baud_rate), shared with the TX side.
- One natural sub-module: sync_2ff, a 2-flop synchroniser with an active-low async reset value parameter RESET_VAL=1.
- The FSM and buffer stay in uart_rx.

Test Plan (CLK_RATE=16, BAUD_RATE=1, so CLKS_PER_BAUD=16; data_read_ready=1 unless stated):
- Drive frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> data_out=0xA5 and data_read_valid pulses for 1 cycle, no error flags.
- Drive rxd_in low for 5 cycles, then high -> no data_read_valid, FSM returns to IDLE, no frame_error.
- Drive 0x3C with stop bit 0, then hold the line low for 40 cycles, then drive 0x81 -> frame_error pulses once, only 0x81 is delivered.
- Hold data_read_ready=0 and send 0x11 then 0x22 -> data_out stays 0x11, overrun pulses once at the 0x22 stop sample, and 0x11 is read after ready rises.
- Send 0x55 and 0xAA back-to-back, asserting data_read_ready exactly on the cycle 0xAA commits -> both bytes are delivered, no overrun.
- Assert areset_n=0 for 3 cycles mid-DATA of 0xF0, release, send 0x0F -> no output for 0xF0, data_out=0x0F, all flags 0 after reset.
- Loopback: TX block txd_out connected to rxd_in, 256 random bytes -> received sequence equals sent, zero errors.
